// File: rtl/pacman_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
// Shared definitions for the Pacman sprite path:
//   - keycodes understood by the sprite mover (same values the USB keyboard
//     path produces)
//   - dir_t, matching the 2-bit heading "flag" reported by the sprite mover
//   - ap_state_t, the keycode autopilot probe/decide/hold states
//   - helpers mapping a direction to its keycode and to its opposite
// No ports (package).
// -----------------------------------------------------------------------------
package pacman_pkg;

    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    // Encoding matches the sprite mover heading flag; also used as the bit
    // index into the 4-bit blocked vector.
    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        P_UP    = 3'd0,
        P_DOWN  = 3'd1,
        P_LEFT  = 3'd2,
        P_RIGHT = 3'd3,
        DECIDE  = 3'd4,
        HOLD    = 3'd5
    } ap_state_t;

    function automatic logic [7:0] dir_to_key(input dir_t d);
        logic [7:0] k;
        case (d)
            DIR_UP:    k = KEY_UP;
            DIR_DOWN:  k = KEY_DOWN;
            DIR_LEFT:  k = KEY_LEFT;
            DIR_RIGHT: k = KEY_RIGHT;
            default:   k = KEY_NONE;
        endcase
        return k;
    endfunction

    // Left<->right and down<->up differ only in bit 0.
    function automatic dir_t dir_opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/autopilot_chooser.sv
// -----------------------------------------------------------------------------
// autopilot_chooser
// Combinational priority pick of the next keycode from the probe results and
// the signed offset to the target.
// Candidate order: primary axis, secondary axis, current heading, then
// up, down, left, right. First candidate that exists and is not blocked wins;
// all four blocked gives KEY_NONE.
// Build option AUTOPILOT_NOREVERSE_EN: the reverse of the current heading is
// dropped from the list and only taken when it is the sole open direction.
// Ports:
//   i_blocked  [3:0]  blocked flags indexed by dir_t
//   i_dx, i_dy [10:0] signed two's-complement target minus ball
//   i_flag     [1:0]  current heading (dir_t encoding)
//   o_keycode  [7:0]  chosen keycode
// -----------------------------------------------------------------------------
module autopilot_chooser
    import pacman_pkg::*;
(
    input  logic [3:0]  i_blocked,
    input  logic [10:0] i_dx,
    input  logic [10:0] i_dy,
    input  logic [1:0]  i_flag,
    output logic [7:0]  o_keycode
);

    logic [10:0] w_adx;
    logic [10:0] w_ady;
    dir_t        w_cand [7];
    logic [6:0]  w_cand_ok;
    dir_t        w_rev;
    logic [3:0]  w_excl;
    dir_t        w_pick;
    logic        w_found;

    // Build the ordered candidate list and take the first open entry.
    always_comb begin
        w_adx = i_dx[10] ? (11'd0 - i_dx) : i_dx;
        w_ady = i_dy[10] ? (11'd0 - i_dy) : i_dy;

        // Ties go to the X axis.
        if (w_adx >= w_ady) begin
            w_cand[0]    = i_dx[10] ? DIR_LEFT : DIR_RIGHT;
            w_cand_ok[0] = (i_dx != 11'd0);
            w_cand[1]    = i_dy[10] ? DIR_UP : DIR_DOWN;
            w_cand_ok[1] = (i_dy != 11'd0);
        end else begin
            w_cand[0]    = i_dy[10] ? DIR_UP : DIR_DOWN;
            w_cand_ok[0] = (i_dy != 11'd0);
            w_cand[1]    = i_dx[10] ? DIR_LEFT : DIR_RIGHT;
            w_cand_ok[1] = (i_dx != 11'd0);
        end
        w_cand[2]    = dir_t'(i_flag);
        w_cand_ok[2] = 1'b1;
        w_cand[3]    = DIR_UP;
        w_cand_ok[3] = 1'b1;
        w_cand[4]    = DIR_DOWN;
        w_cand_ok[4] = 1'b1;
        w_cand[5]    = DIR_LEFT;
        w_cand_ok[5] = 1'b1;
        w_cand[6]    = DIR_RIGHT;
        w_cand_ok[6] = 1'b1;

        w_rev = dir_opposite(dir_t'(i_flag));
`ifdef AUTOPILOT_NOREVERSE_EN
        w_excl = 4'b0001 << w_rev;
`else
        w_excl = 4'b0000;
`endif

        w_found = 1'b0;
        w_pick  = DIR_UP;
        for (int i = 0; i < 7; i++) begin
            if (!w_found && w_cand_ok[i] && !i_blocked[w_cand[i]] && !w_excl[w_cand[i]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[i];
            end else begin
                w_found = w_found;
            end
        end

        // Only reachable when the excluded reverse is the sole open way.
        if (!w_found && !i_blocked[w_rev]) begin
            w_found = 1'b1;
            w_pick  = w_rev;
        end else begin
            w_found = w_found;
        end

        o_keycode = w_found ? dir_to_key(w_pick) : KEY_NONE;
    end

endmodule

// File: rtl/keycode_autopilot.sv
// -----------------------------------------------------------------------------
// keycode_autopilot
// Autonomous keycode source for the Pacman sprite mover. Each decision window
// probes the four neighbours of the sprite through an external wall_bounds
// instance (one per frame), picks a keycode steering toward the target, then
// holds it HOLD_FRAMES frames. With enable low the user keycode is passed
// through and the sequencer is parked at P_UP.
// Build option AUTOPILOT_NOREVERSE_EN (see autopilot_chooser) forbids reversing
// the current heading unless it is the only open direction.
// Ports:
//   frame_clk, Reset           clock, asynchronous active-high reset
//   enable                     1 = autopilot drives keycode, 0 = passthrough
//   user_keycode [7:0]         keyboard keycode
//   BallX, BallY [9:0]         sprite position (sampled fresh every probe frame)
//   flag [1:0]                 current heading (00 L, 01 R, 10 D, 11 U)
//   TargetX, TargetY [9:0]     steering target
//   probe_wall                 wall_bounds result for (probe_x, probe_y)
//   probe_x, probe_y [9:0]     registered probe coordinate
//   keycode [7:0]              registered keycode to sprite mover
//   decision_valid             one-frame pulse when a new keycode is latched
// -----------------------------------------------------------------------------
module keycode_autopilot
    import pacman_pkg::*;
#(
    parameter int HOLD_FRAMES = 8,
    parameter int PROBE_DIST  = 17,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic [7:0] user_keycode,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [1:0] flag,
    input  logic [9:0] TargetX,
    input  logic [9:0] TargetY,
    input  logic       probe_wall,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    output logic [7:0] keycode,
    output logic       decision_valid
);

    localparam logic [10:0] C_DIST  = 11'(PROBE_DIST);
    localparam logic [10:0] C_XMAX  = 11'(X_MAX);
    localparam logic [10:0] C_YMAX  = 11'(Y_MAX);
    localparam logic [7:0]  C_HLAST = 8'(HOLD_FRAMES - 1);

    ap_state_t   r_state;
    logic [7:0]  r_hold_cnt;
    logic [3:0]  r_blocked;
    logic        r_probe_oob;
    logic [9:0]  r_probe_x;
    logic [9:0]  r_probe_y;
    logic [7:0]  r_keycode;
    logic        r_decision_valid;

    logic [10:0] w_up_y;
    logic [10:0] w_dn_y;
    logic [10:0] w_lf_x;
    logic [10:0] w_rt_x;
    logic        w_up_oob;
    logic        w_dn_oob;
    logic        w_lf_oob;
    logic        w_rt_oob;
    logic        w_probe_blk;
    logic [3:0]  w_blocked_dec;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [7:0]  w_choice;

    // 11-bit probe coordinates; a borrow or an off-screen result blocks that side.
    assign w_up_y   = {1'b0, BallY} - C_DIST;
    assign w_dn_y   = {1'b0, BallY} + C_DIST;
    assign w_lf_x   = {1'b0, BallX} - C_DIST;
    assign w_rt_x   = {1'b0, BallX} + C_DIST;
    assign w_up_oob = ({1'b0, BallY} < C_DIST) || (w_up_y > C_YMAX);
    assign w_dn_oob = (w_dn_y > C_YMAX);
    assign w_lf_oob = ({1'b0, BallX} < C_DIST) || (w_lf_x > C_XMAX);
    assign w_rt_oob = (w_rt_x > C_XMAX);

    // Result for the coordinate presented last frame.
    assign w_probe_blk = probe_wall | r_probe_oob;

    // DECIDE samples the right probe on the same edge the keycode is latched,
    // so the chooser sees that bit live rather than from r_blocked.
    assign w_blocked_dec = {r_blocked[3:2], w_probe_blk, r_blocked[0]};

    assign w_dx = {1'b0, TargetX} - {1'b0, BallX};
    assign w_dy = {1'b0, TargetY} - {1'b0, BallY};

    autopilot_chooser u_chooser (
        .i_blocked (w_blocked_dec),
        .i_dx      (w_dx),
        .i_dy      (w_dy),
        .i_flag    (flag),
        .o_keycode (w_choice)
    );

    // Probe/decide/hold sequencer with registered outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state          <= P_UP;
            r_hold_cnt       <= 8'd0;
            r_blocked        <= 4'b0000;
            r_probe_oob      <= 1'b0;
            r_probe_x        <= 10'd0;
            r_probe_y        <= 10'd0;
            r_keycode        <= KEY_NONE;
            r_decision_valid <= 1'b0;
        end else if (!enable) begin
            r_state          <= P_UP;
            r_hold_cnt       <= 8'd0;
            r_keycode        <= user_keycode;
            r_decision_valid <= 1'b0;
        end else begin
            r_decision_valid <= 1'b0;
            case (r_state)
                P_UP: begin
                    r_probe_x   <= BallX;
                    r_probe_y   <= w_up_y[9:0];
                    r_probe_oob <= w_up_oob;
                    r_state     <= P_DOWN;
                end
                P_DOWN: begin
                    r_blocked[DIR_UP] <= w_probe_blk;
                    r_probe_x         <= BallX;
                    r_probe_y         <= w_dn_y[9:0];
                    r_probe_oob       <= w_dn_oob;
                    r_state           <= P_LEFT;
                end
                P_LEFT: begin
                    r_blocked[DIR_DOWN] <= w_probe_blk;
                    r_probe_x           <= w_lf_x[9:0];
                    r_probe_y           <= BallY;
                    r_probe_oob         <= w_lf_oob;
                    r_state             <= P_RIGHT;
                end
                P_RIGHT: begin
                    r_blocked[DIR_LEFT] <= w_probe_blk;
                    r_probe_x           <= w_rt_x[9:0];
                    r_probe_y           <= BallY;
                    r_probe_oob         <= w_rt_oob;
                    r_state             <= DECIDE;
                end
                DECIDE: begin
                    r_blocked[DIR_RIGHT] <= w_probe_blk;
                    r_keycode            <= w_choice;
                    r_decision_valid     <= 1'b1;
                    r_hold_cnt           <= 8'd0;
                    r_state              <= HOLD;
                end
                HOLD: begin
                    if (r_hold_cnt >= C_HLAST) begin
                        r_hold_cnt <= 8'd0;
                        r_state    <= P_UP;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_hold_cnt <= 8'd0;
                    r_state    <= P_UP;
                end
            endcase
        end
    end

    assign probe_x        = r_probe_x;
    assign probe_y        = r_probe_y;
    assign keycode        = r_keycode;
    assign decision_valid = r_decision_valid;

endmodule

// File: tb/tb_keycode_autopilot.sv
// -----------------------------------------------------------------------------
// tb_keycode_autopilot
// Directed, table-driven bench for keycode_autopilot with default parameters.
// A small wall model answers probe_wall from the probe coordinate: each of the
// four neighbour positions of the ball maps to one bit of the wall mask.
// -----------------------------------------------------------------------------
module tb_keycode_autopilot;

    logic       frame_clk;
    logic       Reset;
    logic       enable;
    logic [7:0] user_keycode;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [1:0] flag;
    logic [9:0] target_x;
    logic [9:0] target_y;
    logic       probe_wall;
    logic [9:0] probe_x;
    logic [9:0] probe_y;
    logic [7:0] keycode;
    logic       decision_valid;

    // wall mask bits: [3] up, [2] down, [1] right, [0] left
    logic [3:0] wall;

    int n_tests = 0;
    int n_fail  = 0;

    keycode_autopilot dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .enable         (enable),
        .user_keycode   (user_keycode),
        .BallX          (ball_x),
        .BallY          (ball_y),
        .flag           (flag),
        .TargetX        (target_x),
        .TargetY        (target_y),
        .probe_wall     (probe_wall),
        .probe_x        (probe_x),
        .probe_y        (probe_y),
        .keycode        (keycode),
        .decision_valid (decision_valid)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    logic [9:0] m_up_y;
    logic [9:0] m_dn_y;
    logic [9:0] m_lf_x;
    logic [9:0] m_rt_x;
    assign m_up_y = ball_y - 10'd17;
    assign m_dn_y = ball_y + 10'd17;
    assign m_lf_x = ball_x - 10'd17;
    assign m_rt_x = ball_x + 10'd17;

    // Wall model: combinational answer for the probed neighbour.
    always_comb begin
        probe_wall = 1'b0;
        if (probe_x == ball_x && probe_y == m_up_y) begin
            probe_wall = wall[3];
        end else if (probe_x == ball_x && probe_y == m_dn_y) begin
            probe_wall = wall[2];
        end else if (probe_y == ball_y && probe_x == m_lf_x) begin
            probe_wall = wall[0];
        end else if (probe_y == ball_y && probe_x == m_rt_x) begin
            probe_wall = wall[1];
        end else begin
            probe_wall = 1'b0;
        end
    end

    typedef struct {
        logic [9:0] bx;
        logic [9:0] by;
        logic [9:0] tx;
        logic [9:0] ty;
        logic [1:0] flg;
        logic [3:0] wl;
        logic [7:0] ukey;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

`ifdef AUTOPILOT_NOREVERSE_EN
    localparam logic [7:0] EXP_V5  = 8'h04;
    localparam logic [7:0] EXP_V12 = 8'h07;
`else
    localparam logic [7:0] EXP_V5  = 8'h1A;
    localparam logic [7:0] EXP_V12 = 8'h04;
`endif

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{10'd320, 10'd350, 10'd100, 10'd340, 2'b00, 4'b0000, 8'h16, 8'h04};
        vecs[1]  = '{10'd320, 10'd350, 10'd100, 10'd300, 2'b00, 4'b0001, 8'h55, 8'h1A};
        vecs[2]  = '{10'd320, 10'd350, 10'd100, 10'd300, 2'b01, 4'b1001, 8'h55, 8'h07};
        vecs[3]  = '{10'd320, 10'd10,  10'd100, 10'd300, 2'b00, 4'b0111, 8'h55, 8'h00};
        vecs[4]  = '{10'd200, 10'd200, 10'd200, 10'd200, 2'b10, 4'b0000, 8'h55, 8'h16};
        vecs[5]  = '{10'd200, 10'd200, 10'd200, 10'd200, 2'b10, 4'b0100, 8'h55, EXP_V5};
        vecs[6]  = '{10'd100, 10'd100, 10'd110, 10'd400, 2'b10, 4'b0000, 8'h55, 8'h16};
        vecs[7]  = '{10'd100, 10'd100, 10'd110, 10'd400, 2'b10, 4'b0100, 8'h55, 8'h07};
        vecs[8]  = '{10'd300, 10'd470, 10'd300, 10'd479, 2'b11, 4'b0000, 8'h55, 8'h1A};
        vecs[9]  = '{10'd630, 10'd240, 10'd639, 10'd240, 2'b00, 4'b0000, 8'h55, 8'h04};
        vecs[10] = '{10'd5,   10'd240, 10'd0,   10'd240, 2'b00, 4'b0000, 8'h55, 8'h1A};
        vecs[11] = '{10'd320, 10'd350, 10'd100, 10'd340, 2'b00, 4'b1111, 8'h55, 8'h00};
        vecs[12] = '{10'd320, 10'd350, 10'd100, 10'd350, 2'b01, 4'b0000, 8'h55, EXP_V12};
        vecs[13] = '{10'd320, 10'd350, 10'd100, 10'd350, 2'b01, 4'b1110, 8'h55, 8'h04};
        vecs[14] = '{10'd200, 10'd200, 10'd250, 10'd150, 2'b01, 4'b0000, 8'h55, 8'h07};
        vecs[15] = '{10'd320, 10'd350, 10'd100, 10'd340, 2'b11, 4'b1011, 8'h55, 8'h16};

        Reset        = 1'b1;
        enable       = 1'b0;
        user_keycode = 8'h00;
        ball_x       = 10'd0;
        ball_y       = 10'd0;
        flag         = 2'b00;
        target_x     = 10'd0;
        target_y     = 10'd0;
        wall         = 4'b0000;
        #2;
        check("reset keycode", 16'(keycode), 16'h00);
        check("reset probe_x", 16'(probe_x), 16'h0);
        check("reset probe_y", 16'(probe_y), 16'h0);
        check("reset dv",      16'(decision_valid), 16'h0);
        step();
        step();
        Reset = 1'b0;

        // Table: passthrough, re-enable latency, decision value, single pulse.
        for (int v = 0; v < NV; v++) begin
            ball_x       = vecs[v].bx;
            ball_y       = vecs[v].by;
            target_x     = vecs[v].tx;
            target_y     = vecs[v].ty;
            flag         = vecs[v].flg;
            wall         = vecs[v].wl;
            user_keycode = vecs[v].ukey;
            enable       = 1'b0;
            step();
            check($sformatf("v%0d passthru", v), 16'(keycode), 16'(vecs[v].ukey));
            enable = 1'b1;
            for (int e = 1; e <= 4; e++) begin
                step();
            end
            check($sformatf("v%0d held edge4", v), 16'(keycode), 16'(vecs[v].ukey));
            check($sformatf("v%0d dv edge4", v), 16'(decision_valid), 16'h0);
            step();
            check($sformatf("v%0d decision", v), 16'(keycode), 16'(vecs[v].exp));
            check($sformatf("v%0d dv edge5", v), 16'(decision_valid), 16'h1);
            step();
            check($sformatf("v%0d dv edge6", v), 16'(decision_valid), 16'h0);
            check($sformatf("v%0d key edge6", v), 16'(keycode), 16'(vecs[v].exp));
        end

        // Full period: decision at edge 5, hold, next decision at edge 18.
        ball_x   = 10'd320;
        ball_y   = 10'd350;
        target_x = 10'd100;
        target_y = 10'd340;
        flag     = 2'b00;
        wall     = 4'b0000;
        user_keycode = 8'h16;
        enable   = 1'b0;
        step();
        enable = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
        end
        check("period first key", 16'(keycode), 16'h04);
        wall = 4'b0001;
        for (int e = 6; e <= 17; e++) begin
            step();
            check($sformatf("period key e%0d", e), 16'(keycode), 16'h04);
            check($sformatf("period dv e%0d", e), 16'(decision_valid), 16'h0);
        end
        step();
        check("period second key", 16'(keycode), 16'h1A);
        check("period second dv", 16'(decision_valid), 16'h1);

        // Reset in the middle of HOLD, then a fresh 5-frame decision.
        step();
        step();
        #2;
        Reset = 1'b1;
        #1;
        check("midreset keycode", 16'(keycode), 16'h00);
        check("midreset probe_x", 16'(probe_x), 16'h0);
        check("midreset probe_y", 16'(probe_y), 16'h0);
        check("midreset dv",      16'(decision_valid), 16'h0);
        @(posedge frame_clk);
        #3;
        Reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
        end
        check("postreset key edge4", 16'(keycode), 16'h00);
        step();
        check("postreset key edge5", 16'(keycode), 16'h1A);
        check("postreset dv edge5", 16'(decision_valid), 16'h1);

        // Disable mid-probe aborts and passes through on the next edge.
        step();
        step();
        step();
        step();
        step();
        step();
        step();
        step();
        step();
        step();
        user_keycode = 8'h16;
        enable = 1'b0;
        step();
        check("abort passthru", 16'(keycode), 16'h16);
        check("abort dv", 16'(decision_valid), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
